// File: rtl/if_align_buffer.sv
// if_align_buffer: realigns fetch blocks into one RVC or 32-bit instruction per cycle.
// Ports:
//   clk, rst_n                      clock, synchronous active-low reset
//   fetch_valid_i/ready_o           fetch block handshake (ready = room for a whole block)
//   fetch_addr_i/data_i/fault_i     block address (low bits = start offset), data, fault tag
//   flush_i, flush_pc_i             redirect: empty the queue and restart at flush_pc_i
//   inst_valid_o/ready_i            aligned instruction handshake
//   inst_pc_o/data_o/rvc_o          instruction PC, raw bits (RVC zero-extended), 16-bit flag
//   inst_fault_o/tval_o             fault flag and faulting halfword address
//   expect_pc_o                     next fetch address the queue will accept
module if_align_buffer #(
  parameter int          FETCH_W  = 64,
  parameter int          DEPTH    = 8,
  parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               fetch_valid_i,
  output logic               fetch_ready_o,
  input  logic [31:0]        fetch_addr_i,
  input  logic [FETCH_W-1:0] fetch_data_i,
  input  logic               fetch_fault_i,
  input  logic               flush_i,
  input  logic [31:0]        flush_pc_i,
  output logic               inst_valid_o,
  input  logic               inst_ready_i,
  output logic [31:0]        inst_pc_o,
  output logic [31:0]        inst_data_o,
  output logic               inst_rvc_o,
  output logic               inst_fault_o,
  output logic [31:0]        inst_tval_o,
  output logic [31:0]        expect_pc_o
);
  localparam int NH = FETCH_W / 16;
  localparam int OB = $clog2(FETCH_W / 8);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] NH_C = CW'(NH);
  localparam logic [31:0] BLK_B = 32'(FETCH_W / 8);

  logic [16:0]   mem [DEPTH];
  logic [AW-1:0] rd, wr;
  logic [CW-1:0] count, push_n, pop_n;
  logic [31:0]   head_pc, expect_pc;
  logic [OB-2:0] off;
  logic [16:0]   h0, h1;
  logic          take, f0, rvc0, fire;

  assign off           = fetch_addr_i[OB-1:1];
  assign fetch_ready_o = (DEPTH_C - count) >= NH_C;
  // A stale block is still consumed but pushes nothing.
  assign take          = fetch_valid_i & fetch_ready_o & ~flush_i & (fetch_addr_i == expect_pc);
  assign push_n        = take ? NH_C - CW'(off) : '0;
  assign h0            = mem[rd];
  assign h1            = mem[rd + AW'(1)];
  assign f0            = h0[16];
  assign rvc0          = h0[1:0] != 2'b11;
  // A 32-bit head waits for its upper half; a faulted head goes out alone.
  assign inst_valid_o  = (count != '0) & (f0 | rvc0 | (count >= CW'(2)));
  assign fire          = inst_valid_o & inst_ready_i;
  assign pop_n         = !fire ? '0 : (f0 | rvc0) ? CW'(1) : CW'(2);
  assign inst_rvc_o    = inst_valid_o & ~f0 & rvc0;
  assign inst_fault_o  = inst_valid_o & (f0 | (~rvc0 & h1[16]));
  assign inst_pc_o     = inst_valid_o ? head_pc : '0;
  assign inst_data_o   = (!inst_valid_o || f0) ? '0 : rvc0 ? {16'h0, h0[15:0]} : {h1[15:0], h0[15:0]};
  assign inst_tval_o   = !inst_fault_o ? '0 : f0 ? head_pc : head_pc + 32'd2;
  assign expect_pc_o   = expect_pc;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd        <= '0;
      wr        <= '0;
      count     <= '0;
      head_pc   <= RESET_PC;
      expect_pc <= RESET_PC;
    end else if (flush_i) begin
      rd        <= '0;
      wr        <= '0;
      count     <= '0;
      head_pc   <= flush_pc_i;
      expect_pc <= flush_pc_i;
    end else begin
      rd      <= rd + AW'(pop_n);
      wr      <= wr + AW'(push_n);
      count   <= count + push_n - pop_n;
      head_pc <= head_pc + (32'(pop_n) << 1);
      if (take) expect_pc <= {fetch_addr_i[31:OB], OB'(0)} + BLK_B;
    end
  end

  // Halfwords from the start offset upward land in consecutive slots from wr.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NH; i++)
      if (take && i >= int'(off)) mem[wr + AW'(i - int'(off))] <= {fetch_fault_i, fetch_data_i[16*i +: 16]};
  end
endmodule

// File: tb/tb_if_align_buffer.sv
// tb_if_align_buffer: randomized scoreboard bench for if_align_buffer against a halfword-queue model.
module tb_if_align_buffer;
  localparam int FW = 64;
  localparam int DP = 8;
  localparam int NH = FW / 16;
  localparam logic [31:0] RPC = 32'h8000_0000;

  typedef struct {logic [15:0] d; logic f; logic [31:0] pc;} hw_t;
  typedef struct {logic [31:0] pc, data, tval; logic rvc, fault; int n;} ins_t;

  logic clk = 0, rst_n, fetch_valid, fetch_ready, fetch_fault, flush, inst_valid, inst_ready;
  logic inst_rvc, inst_fault;
  logic [31:0] fetch_addr, flush_pc, inst_pc, inst_data, inst_tval, expect_pc;
  logic [FW-1:0] fetch_data;

  hw_t  pend[$];
  ins_t exp_q[$];
  logic [31:0] m_expect;
  int checks = 0, errors = 0;
  bit mon_en = 0;

  if_align_buffer #(.FETCH_W(FW), .DEPTH(DP), .RESET_PC(RPC)) dut (
    .clk(clk), .rst_n(rst_n), .fetch_valid_i(fetch_valid), .fetch_ready_o(fetch_ready),
    .fetch_addr_i(fetch_addr), .fetch_data_i(fetch_data), .fetch_fault_i(fetch_fault),
    .flush_i(flush), .flush_pc_i(flush_pc), .inst_valid_o(inst_valid), .inst_ready_i(inst_ready),
    .inst_pc_o(inst_pc), .inst_data_o(inst_data), .inst_rvc_o(inst_rvc), .inst_fault_o(inst_fault),
    .inst_tval_o(inst_tval), .expect_pc_o(expect_pc)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %h expected %h at %0t", nm, got, want, $time);
    end
  endtask

  function automatic int mcount();
    int s = pend.size();
    foreach (exp_q[i]) s += exp_q[i].n;
    return s;
  endfunction

  // Turn buffered halfwords into every instruction that is complete.
  task automatic decompose();
    ins_t e;
    while (pend.size() > 0) begin
      if (pend[0].f) begin
        e = '{pc: pend[0].pc, data: 0, tval: pend[0].pc, rvc: 0, fault: 1, n: 1};
      end else if (pend[0].d[1:0] != 2'b11) begin
        e = '{pc: pend[0].pc, data: {16'h0, pend[0].d}, tval: 0, rvc: 1, fault: 0, n: 1};
      end else if (pend.size() >= 2) begin
        e = '{pc: pend[0].pc, data: {pend[1].d, pend[0].d}, tval: pend[1].f ? pend[0].pc + 2 : 0,
              rvc: 0, fault: pend[1].f, n: 2};
      end else break;
      exp_q.push_back(e);
      repeat (e.n) void'(pend.pop_front());
    end
  endtask

  always @(negedge clk) if (mon_en) begin
    chk("valid", 32'(inst_valid), 32'(exp_q.size() != 0));
    if (inst_valid && exp_q.size() != 0) begin
      chk("pc", inst_pc, exp_q[0].pc);
      chk("data", inst_data, exp_q[0].data);
      chk("rvc", 32'(inst_rvc), 32'(exp_q[0].rvc));
      chk("fault", 32'(inst_fault), 32'(exp_q[0].fault));
      chk("tval", inst_tval, exp_q[0].tval);
      if (inst_ready) void'(exp_q.pop_front());
    end
  end

  task automatic step(input bit v, input logic [31:0] a, input logic [FW-1:0] d, input bit f,
                      input bit fl, input logic [31:0] fpc, input bit rdy, input bit r);
    bit mr;
    logic [31:0] blk;
    fetch_valid = v; fetch_addr = a; fetch_data = d; fetch_fault = f;
    flush = fl; flush_pc = fpc; inst_ready = rdy; rst_n = !r;
    mr = (DP - mcount()) >= NH;
    chk("fetch_ready", 32'(fetch_ready), 32'(mr));
    chk("expect_pc", expect_pc, m_expect);
    @(posedge clk); #1;
    if (r || fl) begin
      pend.delete(); exp_q.delete();
      m_expect = r ? RPC : fpc;
    end else if (v && mr && a == m_expect) begin
      blk = {a[31:3], 3'b000};
      for (int i = int'(a[2:1]); i < NH; i++) pend.push_back('{d: d[16*i +: 16], f: f, pc: blk + 32'(2*i)});
      m_expect = blk + 32'd8;
      decompose();
    end
    fetch_valid = 0; flush = 0; rst_n = 1;
  endtask

  task automatic blk_in(input logic [31:0] a, input logic [FW-1:0] d, input bit f);
    step(1, a, d, f, 0, 0, 1, 0);
  endtask
  task automatic idle(input int n, input bit rdy);
    repeat (n) step(0, 0, 0, 0, 0, 0, rdy, 0);
  endtask
  task automatic fl(input logic [31:0] pc);
    step(0, 0, 0, 0, 1, pc, 1, 0);
  endtask

  initial begin
    rst_n = 0; fetch_valid = 0; fetch_addr = 0; fetch_data = 0; fetch_fault = 0;
    flush = 0; flush_pc = 0; inst_ready = 1; m_expect = RPC;
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
    chk("rst expect_pc", expect_pc, RPC);
    chk("rst fetch_ready", 32'(fetch_ready), 1);
    chk("rst valid", 32'(inst_valid), 0);
    chk("rst pc", inst_pc, 0);
    chk("rst data", inst_data, 0);
    chk("rst rvc", 32'(inst_rvc), 0);
    chk("rst fault", 32'(inst_fault), 0);
    chk("rst tval", inst_tval, 0);
    mon_en = 1;
    blk_in(RPC, 64'h0000_0013_0000_0013, 0); idle(3, 1);
    fl(RPC); blk_in(RPC, {16'h0000, 16'h0513, 16'h4585, 16'h4501}, 0); idle(4, 1);
    fl(RPC); blk_in(RPC, {16'h0513, 16'h4501, 16'h4585, 16'h4501}, 0); idle(4, 1);
    blk_in(RPC + 8, {16'h0001, 16'h0001, 16'h0001, 16'h0000}, 0); idle(6, 1);
    fl(RPC); blk_in(RPC + 8, 64'h0001_0001_0001_0001, 0); idle(2, 1);
    step(1, RPC, 64'h0001_0001_0001_0001, 0, 1, RPC + 32'h106, 1, 0); idle(1, 1);
    blk_in(RPC + 32'h106, {16'h4501, 16'h0001, 16'h0001, 16'h0001}, 0); idle(3, 1);
    fl(RPC + 4);
    repeat (4) step(1, m_expect, 64'h0001_4585_0001_4501, 0, 0, 0, 0, 0);
    idle(3, 0); idle(12, 1);
    fl(RPC + 32'h200); blk_in(RPC + 32'h200, 64'h0013_4501_0000_0513, 1); idle(6, 1);
    fl(RPC + 32'h300); blk_in(RPC + 32'h300, {16'h0513, 16'h0001, 16'h0001, 16'h0001}, 0); idle(4, 1);
    blk_in(RPC + 32'h308, {16'h0001, 16'h0001, 16'h0001, 16'h0000}, 1); idle(6, 1);
    for (int k = 0; k < 3000; k++) begin
      logic [31:0] a;
      a = ($urandom % 6 == 0) ? m_expect + (($urandom % 2 == 0) ? 32'd8 : 32'd2) : m_expect;
      step($urandom % 4 != 0, a, {$urandom, $urandom}, $urandom % 12 == 0, $urandom % 30 == 0,
           {RPC[31:12], 11'($urandom), 1'b0}, $urandom % 4 != 0, $urandom % 200 == 0);
    end
    for (int k = 0; k < 40 && exp_q.size() != 0; k++) idle(1, 1);
    chk("drain", 32'(exp_q.size()), 0);
    idle(2, 1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
